// File: rtl/sbox_seq_engine.sv
// DES S-box layer evaluated LANES boxes per cycle over 8/LANES cycles, with an optional
// P permutation. Handshakes are valid/ready: a transfer happens on a rising edge where both are high.
module sbox_seq_engine #(
    parameter int LANES  = 8,
    parameter int P_PERM = 0
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [47:0] in_data,
    input  logic [47:0] in_key,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic        busy
);
    localparam int ITER = 8 / LANES;
    localparam logic [2:0] LAST_CNT = 3'(ITER - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    generate
        if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8) || !(P_PERM == 0 || P_PERM == 1)) begin : g_param_check
            $error("sbox_seq_engine: LANES must be 1, 2, 4 or 8 and P_PERM 0 or 1");
        end
    endgenerate

    // S1..S8 row-major; entry {box,row,col} sits at index 511 - {box,row,col}.
    localparam logic [511:0][3:0] SBOX_ROM = {
        64'hE4D12FB83A6C5907, 64'h0F74E2D1A6CB9538, 64'h41E8D62BFC973A50, 64'hFC8249175B3EA06D,
        64'hF18E6B34972DC05A, 64'h3D47F28EC01A69B5, 64'h0E7BA4D158C6932F, 64'hD8A13F42B67C05E9,
        64'hA09E63F51DC7B428, 64'hD709346A285ECBF1, 64'hD6498F30B12C5AE7, 64'h1AD069874FE3B52C,
        64'h7DE3069A1285BC4F, 64'hD8B56F03472C1AE9, 64'hA690CB7DF13E5284, 64'h3F06A1D8945BC72E,
        64'h2C417AB6853FD0E9, 64'hEB2C47D150FA3986, 64'h421BAD78F9C5630E, 64'hB8C71E2D6F09A453,
        64'hC1AF92680D34E75B, 64'hAF427C9561DE0B38, 64'h9EF528C3704A1DB6, 64'h432C95FABE17608D,
        64'h4B2EF08D3C975A61, 64'hD0B7491AE35C2F86, 64'h14BDC37EAF680592, 64'h6BD814A7950FE23C,
        64'hD2846FB1A93E50C7, 64'h1FD8A374C56B0E92, 64'h7B419CE206ADF358, 64'h21E74A8DFC90356B
    };

    // out[i] = in[P_TAB[i]] in 0-based LSB numbering; first entry is output bit 31.
    localparam logic [31:0][4:0] P_TAB = {
        5'd16, 5'd25, 5'd12, 5'd11, 5'd3,  5'd20, 5'd4,  5'd15,
        5'd31, 5'd17, 5'd9,  5'd6,  5'd27, 5'd14, 5'd1,  5'd22,
        5'd30, 5'd24, 5'd8,  5'd18, 5'd0,  5'd5,  5'd29, 5'd23,
        5'd13, 5'd19, 5'd2,  5'd26, 5'd10, 5'd21, 5'd28, 5'd7
    };

    function automatic logic [3:0] sbox(input logic [2:0] box, input logic [5:0] b);
        logic [8:0] idx;
        idx = {box, b[5], b[0], b[4:1]};
        return SBOX_ROM[~idx];
    endfunction

    function automatic logic [31:0] permute(input logic [31:0] s);
        logic [31:0] r;
        for (int i = 0; i < 32; i++) begin
            r[i] = s[P_TAB[i]];
        end
        return r;
    endfunction

    logic [1:0]  state;
    logic [2:0]  cnt;
    logic [47:0] operand;
    logic [31:0] work;
    logic [31:0] next_work;
    logic [31:0] final_data;
    logic [31:0] out_q;
    logic        accept;

    assign in_ready  = reset_n && ((state == S_IDLE) || ((state == S_DONE) && out_ready));
    assign accept    = in_valid && in_ready;
    assign out_valid = (state == S_DONE);
    assign busy      = (state == S_BUSY);
    assign out_data  = out_q;

    always_comb begin
        next_work = work;
        for (int l = 0; l < LANES; l++) begin : lane
            logic [2:0] box;
            box = 3'(int'(cnt) * LANES + l);
            next_work[(7 - int'(box)) * 4 +: 4] = sbox(box, operand[(7 - int'(box)) * 6 +: 6]);
        end
    end

    assign final_data = (P_PERM != 0) ? permute(next_work) : next_work;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state   <= S_IDLE;
            cnt     <= '0;
            operand <= '0;
            work    <= '0;
            out_q   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        operand <= in_data ^ in_key;
                        cnt     <= '0;
                        state   <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    work <= next_work;
                    cnt  <= cnt + 3'd1;
                    if (cnt == LAST_CNT) begin
                        out_q <= final_data;
                        state <= S_DONE;
                    end
                end
                S_DONE: begin
                    // Result handoff and next acceptance share one edge for back-to-back operation.
                    if (accept) begin
                        operand <= in_data ^ in_key;
                        cnt     <= '0;
                        state   <= S_BUSY;
                    end else if (out_ready) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sbox_seq_engine.sv
// Bench for sbox_seq_engine: one instance per LANES/P_PERM combination, directed table,
// hand-written backpressure and reset sequences, and randomized traffic against a reference model.
module tb_sbox_seq_engine;
    logic        clk = 1'b0;
    logic        reset_n;
    logic        in_valid  [8];
    logic [47:0] in_data   [8];
    logic [47:0] in_key    [8];
    logic        out_ready [8];
    logic        in_ready  [8];
    logic        out_valid [8];
    logic [31:0] out_data  [8];
    logic        busy      [8];

    int n_vec = 0;
    int n_err = 0;
    logic [31:0] exp_q[$];

    always #5 clk = ~clk;

    // Instance k: LANES = 1 << (k/2), P_PERM = k % 2.
    for (genvar g = 0; g < 8; g++) begin : g_dut
        sbox_seq_engine #(.LANES(1 << (g / 2)), .P_PERM(g % 2)) u_dut (
            .clk(clk), .reset_n(reset_n),
            .in_valid(in_valid[g]), .in_ready(in_ready[g]),
            .in_data(in_data[g]), .in_key(in_key[g]),
            .out_valid(out_valid[g]), .out_ready(out_ready[g]),
            .out_data(out_data[g]), .busy(busy[g])
        );
    end

    int sbox_tab [8][64] = '{
        '{14,4,13,1,2,15,11,8,3,10,6,12,5,9,0,7,  0,15,7,4,14,2,13,1,10,6,12,11,9,5,3,8,
          4,1,14,8,13,6,2,11,15,12,9,7,3,10,5,0,  15,12,8,2,4,9,1,7,5,11,3,14,10,0,6,13},
        '{15,1,8,14,6,11,3,4,9,7,2,13,12,0,5,10,  3,13,4,7,15,2,8,14,12,0,1,10,6,9,11,5,
          0,14,7,11,10,4,13,1,5,8,12,6,9,3,2,15,  13,8,10,1,3,15,4,2,11,6,7,12,0,5,14,9},
        '{10,0,9,14,6,3,15,5,1,13,12,7,11,4,2,8,  13,7,0,9,3,4,6,10,2,8,5,14,12,11,15,1,
          13,6,4,9,8,15,3,0,11,1,2,12,5,10,14,7,  1,10,13,0,6,9,8,7,4,15,14,3,11,5,2,12},
        '{7,13,14,3,0,6,9,10,1,2,8,5,11,12,4,15,  13,8,11,5,6,15,0,3,4,7,2,12,1,10,14,9,
          10,6,9,0,12,11,7,13,15,1,3,14,5,2,8,4,  3,15,0,6,10,1,13,8,9,4,5,11,12,7,2,14},
        '{2,12,4,1,7,10,11,6,8,5,3,15,13,0,14,9,  14,11,2,12,4,7,13,1,5,0,15,10,3,9,8,6,
          4,2,1,11,10,13,7,8,15,9,12,5,6,3,0,14,  11,8,12,7,1,14,2,13,6,15,0,9,10,4,5,3},
        '{12,1,10,15,9,2,6,8,0,13,3,4,14,7,5,11,  10,15,4,2,7,12,9,5,6,1,13,14,0,11,3,8,
          9,14,15,5,2,8,12,3,7,0,4,10,1,13,11,6,  4,3,2,12,9,5,15,10,11,14,1,7,6,0,8,13},
        '{4,11,2,14,15,0,8,13,3,12,9,7,5,10,6,1,  13,0,11,7,4,9,1,10,14,3,5,12,2,15,8,6,
          1,4,11,13,12,3,7,14,10,15,6,8,0,5,9,2,  6,11,13,8,1,4,10,7,9,5,0,15,14,2,3,12},
        '{13,2,8,4,6,15,11,1,10,9,3,14,5,0,12,7,  1,15,13,8,10,3,7,4,12,5,6,11,0,14,9,2,
          7,11,4,1,9,12,14,2,0,6,10,13,15,3,5,8,  2,1,14,7,4,10,8,13,15,12,9,0,3,5,6,11}
    };

    // DES P table, 1-based with bit 1 as the MSB.
    int p_tab [32] = '{16,7,20,21,29,12,28,17,1,15,23,26,5,18,31,10,
                       2,8,24,14,32,27,3,9,19,13,30,6,22,11,4,25};

    function automatic logic [31:0] ref_model(input logic [47:0] d, input logic [47:0] key, input int pp);
        logic [47:0] x;
        logic [31:0] raw;
        logic [31:0] res;
        int chunk, row, col;
        x = d ^ key;
        raw = '0;
        for (int s = 0; s < 8; s++) begin
            chunk = int'((x >> (42 - 6 * s)) & 48'h3F);
            row = (chunk / 32) * 2 + (chunk % 2);
            col = (chunk / 2) % 16;
            raw = (raw << 4) | 32'(sbox_tab[s][row * 16 + col]);
        end
        if (pp == 0) return raw;
        res = '0;
        for (int j = 0; j < 32; j++) begin
            res = (res << 1) | ((raw >> (32 - p_tab[j])) & 32'd1);
        end
        return res;
    endfunction

    function automatic logic [47:0] rand48();
        return {16'($urandom), 32'($urandom)};
    endfunction

    function automatic int iter_of(input int k);
        return 8 >> (k / 2);
    endfunction

    task automatic check(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s inst %0d: got %h, expected %h", name, k, act, exp);
        end
    endtask

    // One complete operation with no backpressure; operands are scrambled while busy.
    task automatic do_op(input int k, input logic [47:0] d, input logic [47:0] key,
                         input logic [31:0] exp, input string name);
        int lat;
        @(negedge clk);
        in_valid[k] = 1'b1; in_data[k] = d; in_key[k] = key; out_ready[k] = 1'b0;
        #1 check({name, "_ready_idle"}, k, 32'(in_ready[k]), 32'd1);
        @(posedge clk);
        @(negedge clk);
        in_valid[k] = 1'b0; in_data[k] = rand48(); in_key[k] = rand48();
        check({name, "_busy"}, k, 32'(busy[k]), 32'd1);
        #1 check({name, "_ready_busy"}, k, 32'(in_ready[k]), 32'd0);
        lat = 0;
        while (!out_valid[k] && lat < 20) begin
            @(posedge clk);
            @(negedge clk);
            in_data[k] = rand48(); in_key[k] = rand48();
            lat++;
        end
        check({name, "_latency"}, k, 32'(lat), 32'(iter_of(k)));
        check({name, "_data"}, k, out_data[k], exp);
        out_ready[k] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready[k] = 1'b0;
        check({name, "_drained"}, k, 32'(out_valid[k]), 32'd0);
    endtask

    task automatic run_random(input int k, input int n);
        int sent, got, cyc, stray;
        bit hold;
        sent = 0; got = 0; cyc = 0; hold = 1'b0;
        exp_q.delete();
        while (got < n && cyc < 40 * n + 200) begin
            @(negedge clk);
            cyc++;
            out_ready[k] = ($urandom_range(0, 2) != 0);
            if (!hold) begin
                in_valid[k] = (sent < n) && ($urandom_range(0, 3) != 0);
                in_data[k] = rand48();
                in_key[k] = rand48();
            end
            #1;
            if (out_valid[k]) begin
                if (exp_q.size() == 0) begin
                    n_vec++; n_err++;
                    $display("FAIL rand_spurious_valid inst %0d: got out_valid=1, expected no result outstanding", k);
                end else begin
                    check("rand_data", k, out_data[k], exp_q[0]);
                    if (out_ready[k]) begin
                        void'(exp_q.pop_front());
                        got++;
                    end
                end
            end
            if (in_valid[k] && in_ready[k]) begin
                exp_q.push_back(ref_model(in_data[k], in_key[k], k % 2));
                sent++;
                hold = 1'b0;
            end else begin
                hold = in_valid[k];
            end
        end
        @(negedge clk);
        in_valid[k] = 1'b0; out_ready[k] = 1'b0;
        check("rand_results", k, 32'(got), 32'(n));
        stray = 0;
        repeat (iter_of(k) + 3) begin
            @(negedge clk);
            if (out_valid[k]) stray++;
        end
        check("rand_no_extra", k, 32'(stray), 32'd0);
    endtask

    typedef struct {
        int          inst;
        logic [47:0] data;
        logic [47:0] key;
        logic [31:0] exp;
    } vec_t;

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[10];
        logic [47:0] d;
        logic [47:0] key;
        logic [31:0] exp_a;
        logic [31:0] exp_b;
        int lat;
        int highs;

        vecs[0] = '{6, 48'h0,            48'h0,            32'hEFA72C4D};
        vecs[1] = '{0, 48'h0,            48'hFFFFFFFFFFFF, 32'hD9CE3DCB};
        vecs[2] = '{3, 48'h0,            48'h0,            32'hD8D8DBBC};
        vecs[3] = '{6, 48'hFFFFFFFFFFFF, 48'h0,            32'hD9CE3DCB};
        vecs[4] = '{0, 48'hFFFFFFFFFFFF, 48'hFFFFFFFFFFFF, 32'hEFA72C4D};
        vecs[5] = '{2, 48'h0,            48'h0,            32'hEFA72C4D};
        vecs[6] = '{4, 48'h0,            48'hFFFFFFFFFFFF, 32'hD9CE3DCB};
        vecs[7] = '{7, 48'h0,            48'h0,            32'hD8D8DBBC};
        vecs[8] = '{5, 48'h0,            48'h0,            32'hD8D8DBBC};
        vecs[9] = '{1, 48'h0,            48'h0,            32'hD8D8DBBC};

        // Clock and reset.
        reset_n = 1'b0;
        for (int k = 0; k < 8; k++) begin
            in_valid[k] = 1'b0; in_data[k] = '0; in_key[k] = '0; out_ready[k] = 1'b0;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int k = 0; k < 8; k++) begin
            check("reset_in_ready", k, 32'(in_ready[k]), 32'd0);
            check("reset_out_valid", k, 32'(out_valid[k]), 32'd0);
            check("reset_busy", k, 32'(busy[k]), 32'd0);
            check("reset_out_data", k, out_data[k], 32'h0);
        end
        reset_n = 1'b1;
        @(negedge clk);
        for (int k = 0; k < 8; k++) check("idle_in_ready", k, 32'(in_ready[k]), 32'd1);

        // Directed table.
        for (int i = 0; i < 10; i++) begin
            do_op(vecs[i].inst, vecs[i].data, vecs[i].key, vecs[i].exp, "table");
        end

        // Held result under backpressure, then take-and-accept on one edge (LANES=4).
        d = rand48(); key = rand48();
        exp_a = ref_model(d, key, 0);
        @(negedge clk);
        in_valid[4] = 1'b1; in_data[4] = d; in_key[4] = key; out_ready[4] = 1'b0;
        @(posedge clk);
        @(negedge clk);
        in_valid[4] = 1'b0;
        lat = 0;
        while (!out_valid[4] && lat < 20) begin
            @(posedge clk);
            @(negedge clk);
            lat++;
        end
        check("bp_latency", 4, 32'(lat), 32'd2);
        repeat (5) begin
            check("bp_hold_valid", 4, 32'(out_valid[4]), 32'd1);
            check("bp_hold_data", 4, out_data[4], exp_a);
            #1 check("bp_hold_not_ready", 4, 32'(in_ready[4]), 32'd0);
            @(posedge clk);
            @(negedge clk);
        end
        check("bp_last_data", 4, out_data[4], exp_a);
        d = rand48(); key = rand48();
        exp_b = ref_model(d, key, 0);
        in_valid[4] = 1'b1; in_data[4] = d; in_key[4] = key; out_ready[4] = 1'b1;
        #1 check("bp_ready_on_take", 4, 32'(in_ready[4]), 32'd1);
        @(posedge clk);
        @(negedge clk);
        in_valid[4] = 1'b0; out_ready[4] = 1'b0; in_data[4] = rand48();
        check("bp_b_valid_low", 4, 32'(out_valid[4]), 32'd0);
        check("bp_b_busy", 4, 32'(busy[4]), 32'd1);
        @(posedge clk);
        @(negedge clk);
        check("bp_b_still_busy", 4, 32'(out_valid[4]), 32'd0);
        @(posedge clk);
        @(negedge clk);
        check("bp_b_valid", 4, 32'(out_valid[4]), 32'd1);
        check("bp_b_data", 4, out_data[4], exp_b);
        out_ready[4] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready[4] = 1'b0;

        // Reset in the middle of a LANES=1 operation at cnt=3.
        @(negedge clk);
        in_valid[0] = 1'b1; in_data[0] = rand48(); in_key[0] = rand48();
        @(posedge clk);
        @(negedge clk);
        in_valid[0] = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("midrst_out_valid", 0, 32'(out_valid[0]), 32'd0);
        check("midrst_busy", 0, 32'(busy[0]), 32'd0);
        check("midrst_out_data", 0, out_data[0], 32'h0);
        check("midrst_in_ready", 0, 32'(in_ready[0]), 32'd0);
        reset_n = 1'b1;
        highs = 0;
        repeat (12) begin
            @(negedge clk);
            if (out_valid[0]) highs++;
        end
        check("midrst_no_result", 0, 32'(highs), 32'd0);
        d = rand48(); key = rand48();
        do_op(0, d, key, ref_model(d, key, 0), "after_rst");

        // Randomized traffic with backpressure on every configuration.
        for (int k = 0; k < 8; k++) run_random(k, 40);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/sbox_seq_engine.md
SBOX_SEQ_ENGINE -- requirements
Module: sbox_seq_engine

Interface
REQ-001 SHALL have parameter LANES, default 8, number of S-boxes evaluated per cycle; legal values 1, 2, 4, 8.
REQ-002 SHALL have parameter P_PERM, default 0; when 1, the DES P permutation is applied to the 32-bit result.
REQ-003 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset_n, input, 1, synchronous active-low reset, sampled on rising clk.
REQ-005 SHALL have port in_valid, input, 1, request present.
REQ-006 SHALL have port in_ready, output, 1, engine accepts a request this cycle.
REQ-007 SHALL have port in_data, input, 48, expanded half-block; S1 chunk is in_data[47:42] and S8 chunk is in_data[5:0].
REQ-008 SHALL have port in_key, input, 48, round subkey XORed with in_data at acceptance.
REQ-009 SHALL have port out_valid, output, 1, result available.
REQ-010 SHALL have port out_ready, input, 1, consumer takes the result.
REQ-011 SHALL have port out_data, output, 32, result; S1 nibble is [31:28] and S8 nibble is [3:0], before optional P.
REQ-012 SHALL have port busy, output, 1, high while in BUSY state.

Function
REQ-013 SHALL define ITER = 8/LANES; illegal LANES values SHALL fail elaboration.
REQ-014 SHALL implement states IDLE, BUSY, DONE.
REQ-015 Acceptance SHALL occur when in_valid && in_ready; it latches in_data ^ in_key into an internal 48-bit register, clears lane counter cnt to 0, and enters BUSY.
REQ-016 in_ready SHALL be 1 in IDLE, and in DONE when out_ready=1; it SHALL be 0 in BUSY.
REQ-017 Each BUSY cycle SHALL evaluate S-boxes cnt*LANES+1 through cnt*LANES+LANES, write their nibbles into the result register, then increment cnt.
REQ-018 Each S-box SHALL use standard DES tables: row = {b[5],b[0]}, column = b[4:1] of its 6-bit chunk.
REQ-019 When cnt = ITER-1 in BUSY, the next state SHALL be DONE; out_valid SHALL rise exactly ITER cycles after the acceptance edge.
REQ-020 out_valid SHALL be 1 only in DONE; out_data SHALL be stable while out_valid=1 and out_ready=0.
REQ-021 DONE with out_ready=1 and no new acceptance SHALL go to IDLE.
REQ-022 DONE with out_ready=1 and simultaneous acceptance SHALL go directly to BUSY with the new operand; peak throughput is one result per ITER+1 cycles.
REQ-023 in_data and in_key SHALL be ignored outside acceptance cycles; changes during BUSY SHALL not affect the result.
REQ-024 When P_PERM=1, out_data SHALL be P(S-box output) using the DES P table; when P_PERM=0, S-box output is passed unpermuted.
REQ-025 out_data outside DONE SHALL hold its last value.
REQ-026 in_ready SHALL be combinational from state and out_ready only, with no path from in_valid.

Reset
REQ-027 reset_n=0 at a rising edge SHALL force state=IDLE, cnt=0, out_valid=0, busy=0, out_data=0 and the operand register to 0.
REQ-028 While reset_n=0, in_ready SHALL read 0.
REQ-029 Reset asserted mid-BUSY or in DONE SHALL discard the operation with no result emitted; the first acceptance after release SHALL behave as from cold start.

Verification
REQ-030 LANES=8, P_PERM=0, in_data=0, in_key=0 -> out_valid 1 cycle after accept, out_data=0xEFA72C4D.
REQ-031 LANES=1, P_PERM=0, in_data=0, in_key=48'hFFFFFFFFFFFF -> busy for 8 cycles, out_valid on cycle 8, out_data=0xD9CE3DCB.
REQ-032 LANES=2, P_PERM=1, in_data=0, in_key=0 -> out_valid 4 cycles after accept, out_data=0xD8D8DBBC.
REQ-033 LANES=4, out_ready held 0 for 5 cycles after out_valid, then in_valid and out_ready high together with a new operand -> first result is held stable, the new operand is accepted on the same edge the first result is taken, and the second result follows 2 cycles later.
REQ-034 LANES=1, reset_n pulsed low at cnt=3 -> out_valid never rises for that operation, all outputs read reset values, and the next accept yields the correct result after 8 cycles.
REQ-035 Random in_data/in_key with random out_ready backpressure, all LANES and P_PERM combinations -> every out_data matches a combinational reference model, with no dropped or duplicated results.
